// File: rtl/seg_scan_pwm.sv
// N-digit multiplexed 7-segment scanner with PWM brightness, blanking and dead time.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
`timescale 1ns/1ps

module seg_scan_pwm #(
    parameter int DIGITS       = 8,
    parameter int SUB_CYC      = 390,
    parameter int DEAD_CYCLES  = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   digits_bcd,
    input  logic [DIGITS-1:0]     point,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int SC_W = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int DG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SUB_CYC - 1);
    localparam logic [SC_W-1:0] SC_DEAD = SC_W'(DEAD_CYCLES);
    localparam logic [DG_W-1:0] DG_LAST = DG_W'(DIGITS - 1);

    logic [SC_W-1:0]     sub_cnt_q, sub_cnt_d;
    logic [3:0]          sub_idx_q, sub_idx_d;
    logic [DG_W-1:0]     digit_q, digit_d;
    logic                first_q, first_d;

    logic [4*DIGITS-1:0] dig_sh_q, dig_sh_d;
    logic [DIGITS-1:0]   pt_sh_q, pt_sh_d;
    logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic [3:0]          br_sh_q, br_sh_d;

    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                frame_end;
    logic                load;
    logic                dead_zone;
    logic                blink_phase;
    logic                blink_off;
    logic                en;
    logic [3:0]          nib;

    function automatic logic [6:0] dec7(input logic [3:0] v);
        logic [6:0] r;
        unique case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            4'hF: r = 7'h71;
        endcase
        return r;
    endfunction

    assign frame_end = (sub_cnt_q == SC_LAST) && (sub_idx_q == 4'hF)
                    && (digit_q == DG_LAST);
    assign load      = frame_end || first_q;

    always_comb begin
        sub_cnt_d = sub_cnt_q + SC_W'(1);
        sub_idx_d = sub_idx_q;
        digit_d   = digit_q;
        first_d   = 1'b0;
        if (sub_cnt_q == SC_LAST) begin
            sub_cnt_d = '0;
            sub_idx_d = sub_idx_q + 4'd1;
            if (sub_idx_q == 4'hF) begin
                digit_d = (digit_q == DG_LAST) ? '0 : digit_q + DG_W'(1);
            end
        end
    end

    always_comb begin
        dig_sh_d   = dig_sh_q;
        pt_sh_d    = pt_sh_q;
        blank_sh_d = blank_sh_q;
        blink_sh_d = blink_sh_q;
        br_sh_d    = br_sh_q;
        if (load) begin
            dig_sh_d   = digits_bcd;
            pt_sh_d    = point;
            blank_sh_d = blank_mask;
            blink_sh_d = blink_mask;
            br_sh_d    = brightness;
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

    logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + BL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign blink_phase = blink_phase_q;
`else
    assign blink_phase = 1'b0;
`endif

    // Dead time lives entirely inside sub-period 0 because DEAD_CYCLES < SUB_CYC.
    assign dead_zone = (sub_idx_q == 4'd0) && (sub_cnt_q < SC_DEAD);
    assign blink_off = blink_phase & blink_sh_q[digit_q];

    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_q == DG_W'(i)) begin
                nib = dig_sh_q[4*i +: 4];
            end
        end
    end

    assign en = !dead_zone && (sub_idx_q <= br_sh_q)
             && !blank_sh_q[digit_q] && !blink_off;

    always_comb begin
        an_d  = '1;
        seg_d = 8'hFF;
        if (en) begin
            an_d[digit_q] = 1'b0;
            seg_d         = ~{pt_sh_q[digit_q], dec7(nib)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_cnt_q  <= '0;
            sub_idx_q  <= '0;
            digit_q    <= '0;
            first_q    <= 1'b1;
            dig_sh_q   <= '0;
            pt_sh_q    <= '0;
            blank_sh_q <= '0;
            blink_sh_q <= '0;
            br_sh_q    <= '0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
        end else begin
            sub_cnt_q  <= sub_cnt_d;
            sub_idx_q  <= sub_idx_d;
            digit_q    <= digit_d;
            first_q    <= first_d;
            dig_sh_q   <= dig_sh_d;
            pt_sh_q    <= pt_sh_d;
            blank_sh_q <= blank_sh_d;
            blink_sh_q <= blink_sh_d;
            br_sh_q    <= br_sh_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_pwm.sv
// Bench for seg_scan_pwm: frame-level reference model plus directed checks.
// Blink expectations follow `define SEG_BLINK_EN when it is set.
`timescale 1ns/1ps

module tb_seg_scan_pwm;

    localparam int DIGITS  = 4;
    localparam int SUB_CYC = 2;
    localparam int DEAD    = 1;
    localparam int BLINK   = 2;
    localparam int SLOT    = 16 * SUB_CYC;
    localparam int FRAME   = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digits_bcd;
    logic [3:0]  point;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  brightness;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_pwm #(
        .DIGITS       (DIGITS),
        .SUB_CYC      (SUB_CYC),
        .DEAD_CYCLES  (DEAD),
        .BLINK_FRAMES (BLINK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .digits_bcd (digits_bcd),
        .point      (point),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;
    int fd_first = -1;

    logic [15:0] sh_dig;
    logic [3:0]  sh_pt, sh_blank, sh_blink, sh_br;
    logic [6:0]  lut [16];
    int          lit [4];
    logic [7:0]  slot_seg [4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sh_dig = '0; sh_pt = '0; sh_blank = '0; sh_blink = '0; sh_br = '0;
        n = 0;
        fd_first = -1;
    endtask

    task automatic tally_clear();
        for (int i = 0; i < 4; i++) begin
            lit[i] = 0;
            slot_seg[i] = 8'h00;
        end
    endtask

    // One clock: predict output for the counter position 's' that this edge displays.
    task automatic step();
        int s, d, sc;
`ifdef SEG_BLINK_EN
        int f;
`endif
        logic blk, en;
        logic [3:0] nib;
        logic [7:0] es;
        logic [3:0] ea;
        @(posedge clk);
        s = n;
        n++;
        d  = (s % FRAME) / SLOT;
        sc = s % SLOT;
`ifdef SEG_BLINK_EN
        f   = s / FRAME;
        blk = ((f / BLINK) % 2 == 1) && sh_blink[d];
`else
        blk = 1'b0;
`endif
        en  = (sc >= DEAD) && (sc / SUB_CYC <= int'(sh_br))
           && !sh_blank[d] && !blk;
        nib = sh_dig[d*4 +: 4];
        es  = en ? ~{sh_pt[d], lut[nib]} : 8'hFF;
        ea  = en ? ~(4'b0001 << d) : 4'hF;
        if (s == 0 || s % FRAME == FRAME - 1) begin
            sh_dig = digits_bcd; sh_pt = point; sh_blank = blank_mask;
            sh_blink = blink_mask; sh_br = brightness;
        end
        #1;
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("frame_done", 32'(frame_done), 32'(n % FRAME == FRAME - 1));
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                lit[i]++;
                slot_seg[i] = seg;
            end
        end
        if (frame_done && fd_first < 0) fd_first = n;
    endtask

    task automatic run_frame();
        tally_clear();
        repeat (FRAME) step();
    endtask

    initial begin
        lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        digits_bcd = 16'h1A90;
        point      = 4'b0000;
        blank_mask = 4'b0000;
        blink_mask = 4'b0000;
        brightness = 4'd15;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", 32'(seg), 32'h0000_00FF);
        chk("reset_an", 32'(an), 32'h0000_000F);
        chk("reset_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        tally_clear();
        step();
        chk("an_dead_first", 32'(an), 32'h0000_000F);
        step();
        chk("an0_first_low", 32'(an), 32'h0000_000E);
        repeat (FRAME - 2) step();
        chk("fd_first_cycle", 32'(fd_first), 32'(FRAME - 1));
        chk("dec_d0", 32'(slot_seg[0]), 32'h0000_00C0);
        chk("dec_d1", 32'(slot_seg[1]), 32'h0000_0090);
        chk("dec_d2", 32'(slot_seg[2]), 32'h0000_0088);
        chk("dec_d3", 32'(slot_seg[3]), 32'h0000_00F9);
        for (int i = 0; i < 4; i++) chk("lit_br15", 32'(lit[i]), 32'd31);

        brightness = 4'd0;
        run_frame();
        run_frame();
        for (int i = 0; i < 4; i++) chk("lit_br0", 32'(lit[i]), 32'd1);

        brightness = 4'd7;
        run_frame();
        run_frame();
        for (int i = 0; i < 4; i++) chk("lit_br7", 32'(lit[i]), 32'd15);

        brightness = 4'd15;
        run_frame();
        tally_clear();
        repeat (40) step();
        digits_bcd = 16'h2345;
        repeat (FRAME - 40) step();
        chk("tear_hold_d2", 32'(slot_seg[2]), 32'h0000_0088);
        chk("tear_hold_d3", 32'(slot_seg[3]), 32'h0000_00F9);
        run_frame();
        chk("tear_new_d0", 32'(slot_seg[0]), 32'h0000_0092);
        chk("tear_new_d3", 32'(slot_seg[3]), 32'h0000_00A4);

        blank_mask = 4'b0010;
        point      = 4'b0001;
        run_frame();
        run_frame();
        chk("blank_d1", 32'(lit[1]), 32'd0);
        chk("lit_d0_dp", 32'(lit[0]), 32'd31);
        chk("dp_d0", 32'(slot_seg[0][7]), 32'h0);
        chk("dp_d2_off", 32'(slot_seg[2][7]), 32'h1);

        blank_mask = 4'b0000;
        point      = 4'b0000;
        blink_mask = 4'b1000;
        repeat (50) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg), 32'h0000_00FF);
        chk("async_rst_an", 32'(an), 32'h0000_000F);
        chk("async_rst_fd", 32'(frame_done), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        for (int f = 0; f < 6; f++) begin
            int exp_lit;
`ifdef SEG_BLINK_EN
            exp_lit = ((f / 2) % 2 == 1) ? 0 : 31;
`else
            exp_lit = 31;
`endif
            run_frame();
            chk("blink_d3", 32'(lit[3]), 32'(exp_lit));
            chk("blink_d2", 32'(lit[2]), 32'd31);
        end

        for (int f = 0; f < 6; f++) begin
            int k;
            k = $urandom_range(1, FRAME - 2);
            for (int i = 0; i < FRAME; i++) begin
                step();
                if (i == k) begin
                    digits_bcd = 16'($urandom);
                    point      = 4'($urandom);
                    blank_mask = 4'($urandom);
                    blink_mask = 4'($urandom);
                    brightness = 4'($urandom);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
